// File: rtl/fir_run_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_run_scheduler_pkg
// Description : Shared widths, mode codes and state encodings for the FIR
//               run scheduler and its memory-port mux.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_run_scheduler_pkg;

    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 8;
    localparam int CNT_W    = 32;
    localparam int READ_LAT = 2;
    localparam int TIMEOUT  = 4096;

    localparam logic MODE_NP = 1'b0;
    localparam logic MODE_P  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SRC_HOST = 2'd0,
        SRC_NP   = 2'd1,
        SRC_P    = 2'd2
    } mem_src_t;

endpackage
`default_nettype wire

// File: rtl/fir_run_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : fir_run_scheduler_if
// Description : Host access and run-control bundle between the host/test
//               side (master) and the run scheduler (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface fir_run_scheduler_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 32
) ();
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;
    logic              run_start;
    logic              run_sel;
    logic              run_busy;
    logic              run_done;
    logic              run_timeout;
    logic [CNT_W-1:0]  run_cycles;

    modport slave (
        input  host_req, host_we, host_addr, host_wdata, run_start, run_sel,
        output host_gnt, host_rvalid, host_rdata,
        output run_busy, run_done, run_timeout, run_cycles
    );

    modport master (
        output host_req, host_we, host_addr, host_wdata, run_start, run_sel,
        input  host_gnt, host_rvalid, host_rdata,
        input  run_busy, run_done, run_timeout, run_cycles
    );
endinterface
`default_nettype wire

// File: rtl/fir_run_scheduler_mem_mux.sv
`default_nettype none
// ============================================================================
// Module      : fir_run_scheduler_mem_mux
// Description : Three-way sample-memory port mux (host / np / p engine) with
//               port-B write-enable gating. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_run_scheduler_mem_mux
    import fir_run_scheduler_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  mem_src_t          i_src,
    input  logic              i_we_en,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_wdata,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_np_addr_a,
    input  logic [ADDR_W-1:0] i_np_addr_b,
    input  logic              i_np_we_b,
    input  logic [DATA_W-1:0] i_np_wdata_b,
    input  logic [ADDR_W-1:0] i_p_addr_a,
    input  logic [ADDR_W-1:0] i_p_addr_b,
    input  logic              i_p_we_b,
    input  logic [DATA_W-1:0] i_p_wdata_b,
    output logic [ADDR_W-1:0] o_mem_addr_a,
    output logic [ADDR_W-1:0] o_mem_addr_b,
    output logic              o_mem_we_b,
    output logic [DATA_W-1:0] o_mem_data_in_b
);
    logic w_we;

    always_comb begin
        o_mem_addr_a    = i_host_addr;
        o_mem_addr_b    = i_host_addr;
        o_mem_data_in_b = i_host_wdata;
        w_we            = i_host_we;
        case (i_src)
            SRC_NP: begin
                o_mem_addr_a    = i_np_addr_a;
                o_mem_addr_b    = i_np_addr_b;
                o_mem_data_in_b = i_np_wdata_b;
                w_we            = i_np_we_b;
            end
            SRC_P: begin
                o_mem_addr_a    = i_p_addr_a;
                o_mem_addr_b    = i_p_addr_b;
                o_mem_data_in_b = i_p_wdata_b;
                w_we            = i_p_we_b;
            end
            default: ;
        endcase
        o_mem_we_b = w_we & i_we_en;
    end
endmodule
`default_nettype wire

// File: rtl/fir_run_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fir_run_scheduler
// Description : FIR run controller: launches one engine per run, counts its
//               cycles, aborts hung runs and arbitrates the sample memory.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_run_scheduler
    import fir_run_scheduler_pkg::*;
#(
    parameter int ADDR_W   = fir_run_scheduler_pkg::ADDR_W,
    parameter int DATA_W   = fir_run_scheduler_pkg::DATA_W,
    parameter int CNT_W    = fir_run_scheduler_pkg::CNT_W,
    parameter int READ_LAT = fir_run_scheduler_pkg::READ_LAT,
    parameter int TIMEOUT  = fir_run_scheduler_pkg::TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    fir_run_scheduler_if.slave bus,
    output logic              o_np_start,
    output logic              o_p_start,
    input  logic              i_np_done,
    input  logic              i_p_done,
    input  logic [ADDR_W-1:0] i_np_addr_a,
    input  logic [ADDR_W-1:0] i_np_addr_b,
    input  logic              i_np_we_b,
    input  logic [DATA_W-1:0] i_np_wdata_b,
    input  logic [ADDR_W-1:0] i_p_addr_a,
    input  logic [ADDR_W-1:0] i_p_addr_b,
    input  logic              i_p_we_b,
    input  logic [DATA_W-1:0] i_p_wdata_b,
    output logic [ADDR_W-1:0] o_mem_addr_a,
    output logic [ADDR_W-1:0] o_mem_addr_b,
    output logic              o_mem_we_b,
    output logic [DATA_W-1:0] o_mem_data_in_b,
    input  logic [DATA_W-1:0] i_mem_data_out_a
);
    state_t              r_state, w_next;
    logic                r_sel;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    r_cycles;
    logic                r_done;
    logic                r_timeout;
    logic [READ_LAT-1:0] r_rv;

    logic     w_idle, w_gnt, w_sel_done, w_cnt_max, w_we_en;
    mem_src_t w_src;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_gnt      = w_idle & bus.host_req & ~bus.run_start;
    assign w_sel_done = (r_sel == MODE_P) ? i_p_done : i_np_done;
    assign w_cnt_max  = (r_cnt == CNT_W'(TIMEOUT));

    always_comb begin
        w_next     = r_state;
        w_src      = SRC_HOST;
        w_we_en    = 1'b0;
        o_np_start = 1'b0;
        o_p_start  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_we_en = 1'b1;
                if (bus.run_start) w_next = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                w_src      = (r_sel == MODE_P) ? SRC_P : SRC_NP;
                o_np_start = (r_sel == MODE_NP);
                o_p_start  = (r_sel == MODE_P);
                w_next     = ST_RUN;
            end
            ST_RUN: begin
                w_src   = (r_sel == MODE_P) ? SRC_P : SRC_NP;
                w_we_en = 1'b1;
                if (w_sel_done || w_cnt_max) w_next = ST_FINISH;
            end
            ST_FINISH: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_sel     <= MODE_NP;
            r_cnt     <= '0;
            r_cycles  <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_rv      <= '0;
        end else begin
            r_state   <= w_next;
            r_done    <= (r_state == ST_FINISH);
            // A done on the very cycle the limit is hit still counts as a clean finish.
            r_timeout <= (r_state == ST_RUN) & ~w_sel_done & w_cnt_max;
            if (w_idle && bus.run_start) begin
                r_sel <= bus.run_sel;
                r_cnt <= '0;
            end else if (r_state == ST_RUN && !w_cnt_max) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_state == ST_FINISH) r_cycles <= r_cnt;
            // Read-valid pipe runs independently of the FSM so in-flight reads complete.
            r_rv[0] <= w_gnt & ~bus.host_we;
            for (int i = 1; i < READ_LAT; i++) r_rv[i] <= r_rv[i-1];
        end
    end

    assign bus.host_gnt    = w_gnt;
    assign bus.host_rvalid = r_rv[READ_LAT-1];
    assign bus.host_rdata  = r_rv[READ_LAT-1] ? i_mem_data_out_a : '0;
    assign bus.run_busy    = ~w_idle;
    assign bus.run_done    = r_done;
    assign bus.run_timeout = r_timeout;
    assign bus.run_cycles  = r_cycles;

    fir_run_scheduler_mem_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem_mux (
        .i_src           (w_src),
        .i_we_en         (w_we_en),
        .i_host_addr     (bus.host_addr),
        .i_host_wdata    (bus.host_wdata),
        .i_host_we       (w_gnt & bus.host_we),
        .i_np_addr_a     (i_np_addr_a),
        .i_np_addr_b     (i_np_addr_b),
        .i_np_we_b       (i_np_we_b),
        .i_np_wdata_b    (i_np_wdata_b),
        .i_p_addr_a      (i_p_addr_a),
        .i_p_addr_b      (i_p_addr_b),
        .i_p_we_b        (i_p_we_b),
        .i_p_wdata_b     (i_p_wdata_b),
        .o_mem_addr_a    (o_mem_addr_a),
        .o_mem_addr_b    (o_mem_addr_b),
        .o_mem_we_b      (o_mem_we_b),
        .o_mem_data_in_b (o_mem_data_in_b)
    );
endmodule
`default_nettype wire

// File: tb/tb_fir_run_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_run_scheduler
// Description : Self-checking bench for fir_run_scheduler with a 2-clock
//               read-latency memory model and scripted engine responders.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_run_scheduler;
    import fir_run_scheduler_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fir_run_scheduler_if bus ();

    logic       np_start, p_start, np_done, p_done;
    logic [9:0] np_addr_a, np_addr_b, p_addr_a, p_addr_b, mem_addr_a, mem_addr_b;
    logic       np_we_b, p_we_b, mem_we_b;
    logic [7:0] np_wdata_b, p_wdata_b, mem_data_in_b, mem_data_out_a;

    fir_run_scheduler dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .o_np_start      (np_start),
        .o_p_start       (p_start),
        .i_np_done       (np_done),
        .i_p_done        (p_done),
        .i_np_addr_a     (np_addr_a),
        .i_np_addr_b     (np_addr_b),
        .i_np_we_b       (np_we_b),
        .i_np_wdata_b    (np_wdata_b),
        .i_p_addr_a      (p_addr_a),
        .i_p_addr_b      (p_addr_b),
        .i_p_we_b        (p_we_b),
        .i_p_wdata_b     (p_wdata_b),
        .o_mem_addr_a    (mem_addr_a),
        .o_mem_addr_b    (mem_addr_b),
        .o_mem_we_b      (mem_we_b),
        .o_mem_data_in_b (mem_data_in_b),
        .i_mem_data_out_a(mem_data_out_a)
    );

    // Sample memory: registered address plus registered output = 2 clocks.
    logic [7:0] mem [1024];
    logic [7:0] mem_r1, mem_r2;
    logic       mem_init_done = 1'b0;
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
            mem_init_done <= 1'b1;
        end else if (mem_we_b) begin
            mem[mem_addr_b] <= mem_data_in_b;
        end
        mem_r1 <= mem[mem_addr_a];
        mem_r2 <= mem_r1;
    end
    assign mem_data_out_a = mem_r2;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] ref_mem [1024];

    int         o_busy, o_done, o_done_t, o_to, o_nps, o_ps, o_gnt_t, o_leak;
    logic       o_gnt0, o_wr_ok;
    logic [9:0] o_ea, h_addr;
    logic [7:0] h_data;

    task automatic idle_engines();
        np_done = 0; p_done = 0;
        np_we_b = 0; p_we_b = 0;
        np_addr_a = '0; np_addr_b = '0; np_wdata_b = '0;
        p_addr_a  = '0; p_addr_b  = '0; p_wdata_b  = '0;
    endtask

    task automatic host_write(input logic [9:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.host_req = 1; bus.host_we = 1; bus.host_addr = a; bus.host_wdata = d;
        #1;
        n_checks++;
        if (bus.host_gnt !== 1'b1) begin
            n_fail++; $display("FAIL host_write_gnt addr=%0d got=%b exp=1", a, bus.host_gnt);
        end
        @(negedge clk);
        bus.host_req = 0; bus.host_we = 0;
        ref_mem[a] = d;
    endtask

    task automatic host_read(input logic [9:0] a);
        int lat;
        @(negedge clk);
        bus.host_req = 1; bus.host_we = 0; bus.host_addr = a;
        #1;
        n_checks++;
        if (bus.host_gnt !== 1'b1) begin
            n_fail++; $display("FAIL host_read_gnt addr=%0d got=%b exp=1", a, bus.host_gnt);
        end
        @(negedge clk);
        bus.host_req = 0;
        lat = 1;
        while (bus.host_rvalid !== 1'b1 && lat < 6) begin
            @(negedge clk); lat++;
        end
        n_checks++;
        if (lat !== READ_LAT) begin
            n_fail++; $display("FAIL host_read_latency addr=%0d got=%0d exp=%0d", a, lat, READ_LAT);
        end
        n_checks++;
        if (bus.host_rdata !== ref_mem[a]) begin
            n_fail++; $display("FAIL host_read_data addr=%0d got=%0d exp=%0d", a, bus.host_rdata, ref_mem[a]);
        end
    endtask

    // Drive one run; n < 0 means the engine never reports done. The selected
    // engine writes ea/ed at wr_t and also tries to write in LAUNCH/FINISH;
    // the unselected engine requests writes throughout.
    task automatic do_run(input logic sel, input int n, input int spur_t, input int wr_t,
                          input logic hold_host);
        int         limit;
        logic [9:0] la, ua, sa;
        logic [7:0] ed, ld, ud;
        limit = (n < 0) ? TIMEOUT + 8 : n + 6;
        o_ea  = 10'(100 + $urandom_range(0, 99));
        la    = 10'(200 + $urandom_range(0, 99));
        ua    = 10'(300 + $urandom_range(0, 99));
        sa    = 10'($urandom_range(0, 1023));
        ed    = 8'($urandom); ld = 8'($urandom); ud = 8'($urandom);
        o_busy = 0; o_done = 0; o_done_t = -1; o_to = 0; o_nps = 0; o_ps = 0;
        o_gnt_t = -1; o_leak = 0; o_wr_ok = 1'b0;
        @(negedge clk);
        bus.run_start = 1; bus.run_sel = sel;
        if (hold_host) begin
            bus.host_req = 1; bus.host_we = 1; bus.host_addr = h_addr; bus.host_wdata = h_data;
        end
        #1 o_gnt0 = bus.host_gnt;
        @(negedge clk);
        bus.run_start = 0; bus.run_sel = ~sel;
        for (int t = 1; t <= limit; t++) begin
            np_done = (sel == MODE_NP && t == n + 1) || (t == spur_t);
            p_done  = (sel == MODE_P && t == n + 1);
            if (sel == MODE_NP) begin
                np_we_b = (t == 1 || t == wr_t || t == n + 2);
                np_addr_b = (t == wr_t) ? o_ea : la; np_wdata_b = (t == wr_t) ? ed : ld;
                np_addr_a = sa; p_addr_a = ~sa;
                p_we_b = 1; p_addr_b = ua; p_wdata_b = ud;
            end else begin
                p_we_b = (t == 1 || t == wr_t || t == n + 2);
                p_addr_b = (t == wr_t) ? o_ea : la; p_wdata_b = (t == wr_t) ? ed : ld;
                p_addr_a = sa; np_addr_a = ~sa;
                np_we_b = 1; np_addr_b = ua; np_wdata_b = ud;
            end
            #1;
            if (bus.run_busy)    o_busy++;
            if (bus.run_done)    begin o_done++; o_done_t = t; end
            if (bus.run_timeout) o_to++;
            if (np_start)        o_nps++;
            if (p_start)         o_ps++;
            if (bus.host_gnt && o_gnt_t < 0) o_gnt_t = t;
            if (mem_we_b && bus.run_busy && t != wr_t) o_leak++;
            if (t == wr_t)
                o_wr_ok = mem_we_b && mem_addr_b == o_ea && mem_data_in_b == ed && mem_addr_a == sa;
            @(negedge clk);
        end
        idle_engines();
        if (wr_t >= 2) ref_mem[o_ea] = ed;
    endtask

    task automatic test_reset();
        idle_engines();
        bus.host_req = 0; bus.host_we = 0; bus.host_addr = '0; bus.host_wdata = '0;
        bus.run_start = 0; bus.run_sel = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.host_gnt, bus.host_rvalid, bus.run_busy, bus.run_done, bus.run_timeout,
             np_start, p_start, mem_we_b} !== 8'h00) begin
            n_fail++; $display("FAIL reset_flags got=%b exp=00000000", {bus.host_gnt, bus.host_rvalid,
                bus.run_busy, bus.run_done, bus.run_timeout, np_start, p_start, mem_we_b});
        end
        n_checks++;
        if (bus.run_cycles !== '0 || bus.host_rdata !== '0 || mem_addr_a !== '0 ||
            mem_addr_b !== '0 || mem_data_in_b !== '0) begin
            n_fail++; $display("FAIL reset_values cycles=%0d rdata=%0d addr_a=%0d addr_b=%0d exp all 0",
                bus.run_cycles, bus.host_rdata, mem_addr_a, mem_addr_b);
        end
        rst_n = 1;
    endtask

    task automatic test_host_rw();
        host_write(10'd0, 8'd64);
        host_write(10'd10, 8'd32);
        host_read(10'd0);
        host_read(10'd10);
        host_read(10'd20);
        for (int i = 0; i < 6; i++) begin
            h_addr = 10'($urandom_range(400, 1023));
            host_write(h_addr, 8'($urandom));
            host_read(h_addr);
        end
    endtask

    task automatic test_np_run();
        do_run(MODE_NP, 40, 0, $urandom_range(2, 41), 0);
        n_checks++;
        if (o_nps !== 1 || o_ps !== 0) begin
            n_fail++; $display("FAIL np_start_pulses np=%0d p=%0d exp np=1 p=0", o_nps, o_ps);
        end
        n_checks++;
        if (bus.run_cycles !== 32'd40) begin
            n_fail++; $display("FAIL np_run_cycles got=%0d exp=40", bus.run_cycles);
        end
        n_checks++;
        if (o_done !== 1 || o_done_t !== 43) begin
            n_fail++; $display("FAIL np_run_done count=%0d at=%0d exp count=1 at=43", o_done, o_done_t);
        end
        n_checks++;
        if (o_busy !== 42) begin
            n_fail++; $display("FAIL np_run_busy got=%0d exp=42", o_busy);
        end
        n_checks++;
        if (o_leak !== 0 || o_wr_ok !== 1'b1 || o_to !== 0) begin
            n_fail++; $display("FAIL np_run_mem leak=%0d wr_ok=%b timeout=%0d exp 0/1/0", o_leak, o_wr_ok, o_to);
        end
        host_read(o_ea);
    endtask

    task automatic test_p_run_spurious();
        do_run(MODE_P, 12, 4, 7, 0);
        n_checks++;
        if (bus.run_cycles !== 32'd12 || o_to !== 0) begin
            n_fail++; $display("FAIL p_spurious cycles=%0d timeout=%0d exp 12/0", bus.run_cycles, o_to);
        end
        n_checks++;
        if (o_ps !== 1 || o_nps !== 0 || o_done !== 1 || o_done_t !== 15) begin
            n_fail++; $display("FAIL p_spurious_pulses p=%0d np=%0d done=%0d at=%0d exp 1/0/1/15",
                o_ps, o_nps, o_done, o_done_t);
        end
    endtask

    task automatic test_collision();
        int n;
        n      = $urandom_range(8, 20);
        h_addr = 10'($urandom_range(400, 1023));
        h_data = ~ref_mem[h_addr];
        do_run(MODE_NP, n, 0, 0, 1);
        bus.host_req = 0; bus.host_we = 0;
        ref_mem[h_addr] = h_data;
        n_checks++;
        if (o_gnt0 !== 1'b0 || o_gnt_t !== n + 3) begin
            n_fail++; $display("FAIL collision_gnt start_gnt=%b first_gnt_at=%0d exp 0/%0d", o_gnt0, o_gnt_t, n + 3);
        end
        n_checks++;
        if (o_leak !== 0) begin
            n_fail++; $display("FAIL collision_leak writes=%0d exp=0", o_leak);
        end
        host_read(h_addr);
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 4; r++) begin
            logic sel;
            int   n;
            sel = 1'($urandom_range(0, 1));
            n   = $urandom_range(2, 30);
            do_run(sel, n, 0, $urandom_range(2, n + 1), 0);
            n_checks++;
            if (bus.run_cycles !== 32'(n) || o_done_t !== n + 3 || o_busy !== n + 2) begin
                n_fail++; $display("FAIL random_run sel=%0d cycles=%0d done_at=%0d busy=%0d exp %0d/%0d/%0d",
                    sel, bus.run_cycles, o_done_t, o_busy, n, n + 3, n + 2);
            end
            n_checks++;
            if (o_wr_ok !== 1'b1 || o_leak !== 0 || (sel ? o_ps : o_nps) !== 1 || (sel ? o_nps : o_ps) !== 0) begin
                n_fail++; $display("FAIL random_run_mux sel=%0d wr_ok=%b leak=%0d np=%0d p=%0d",
                    sel, o_wr_ok, o_leak, o_nps, o_ps);
            end
            host_read(o_ea);
        end
    endtask

    task automatic test_reset_mid_run();
        int n;
        @(negedge clk);
        bus.host_addr = '0; bus.host_wdata = '0;
        bus.run_start = 1; bus.run_sel = MODE_P;
        @(negedge clk);
        bus.run_start = 0;
        p_we_b = 1; p_addr_a = 10'h3ff; p_addr_b = 10'h155; p_wdata_b = 8'hA5;
        repeat (6) @(negedge clk);
        n_checks++;
        if (bus.run_busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_run_busy got=%b exp=1", bus.run_busy);
        end
        rst_n = 0;
        #1;
        n_checks++;
        if ({bus.host_gnt, bus.host_rvalid, bus.run_busy, bus.run_done, bus.run_timeout,
             np_start, p_start, mem_we_b} !== 8'h00) begin
            n_fail++; $display("FAIL mid_run_reset_flags got=%b exp=00000000", {bus.host_gnt, bus.host_rvalid,
                bus.run_busy, bus.run_done, bus.run_timeout, np_start, p_start, mem_we_b});
        end
        n_checks++;
        if (bus.run_cycles !== '0 || mem_addr_a !== '0 || mem_addr_b !== '0 || mem_data_in_b !== '0) begin
            n_fail++; $display("FAIL mid_run_reset_values cycles=%0d addr_a=%0d addr_b=%0d data=%0d exp 0",
                bus.run_cycles, mem_addr_a, mem_addr_b, mem_data_in_b);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        idle_engines();
        n = $urandom_range(3, 15);
        do_run(MODE_P, n, 0, 2, 0);
        n_checks++;
        if (bus.run_cycles !== 32'(n) || o_ps !== 1 || o_done !== 1) begin
            n_fail++; $display("FAIL after_reset_run cycles=%0d p=%0d done=%0d exp %0d/1/1",
                bus.run_cycles, o_ps, o_done, n);
        end
    endtask

    task automatic test_timeout();
        do_run(1'($urandom_range(0, 1)), -1, 0, 5, 0);
        n_checks++;
        if (o_to !== 1 || o_done !== 1) begin
            n_fail++; $display("FAIL timeout_pulses timeout=%0d done=%0d exp 1/1", o_to, o_done);
        end
        n_checks++;
        if (bus.run_cycles !== 32'(TIMEOUT)) begin
            n_fail++; $display("FAIL timeout_cycles got=%0d exp=%0d", bus.run_cycles, TIMEOUT);
        end
        n_checks++;
        if (bus.run_busy !== 1'b0 || o_busy !== TIMEOUT + 3) begin
            n_fail++; $display("FAIL timeout_idle busy_now=%b busy_cycles=%0d exp 0/%0d",
                bus.run_busy, o_busy, TIMEOUT + 3);
        end
        host_write(10'd999, 8'h5A);
        host_read(10'd999);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        test_reset();
        test_host_rw();
        test_np_run();
        test_p_run_spurious();
        test_collision();
        test_random_runs();
        test_reset_mid_run();
        test_timeout();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fir_run_scheduler.md
# fir_run_scheduler

Run controller and memory-port arbiter for the FIR subsystem. Owns the shared 1024×8 dual-port sample memory: a host port gets load/readback access when idle, and the selected filter engine (non-pipelined or pipelined) gets it while it runs. Launches one engine per run request, measures its cycle count, detects hangs, and reports completion. Sits between the host/test interface and the two filter engines inside the FIR top level.

## Interface
- ADDR_W, 10, sample memory address width
- DATA_W, 8, sample width
- CNT_W, 32, cycle counter width
- READ_LAT, 2, clocks from address presented to mem_data_out_a valid
- TIMEOUT, 4096, cycle limit before a run is aborted
- clk  in  1  system clock; sole clock domain
- rst  in  1  reset, asynchronous assert, active-low
- host_req / host_we  in  1 / 1  host access request; write when host_we=1
- host_addr / host_wdata  in  ADDR_W / DATA_W  host address and write data
- host_gnt  out  1  access accepted this cycle
- host_rvalid / host_rdata  out  1 / DATA_W  read return
- run_start / run_sel  in  1 / 1  run request; 0 = non-pipelined, 1 = pipelined
- run_busy / run_done / run_timeout  out  1 / 1 / 1  status; done and timeout are 1-cycle pulses
- run_cycles  out  CNT_W  cycle count of the last run
- np_start, p_start  out  1  1-cycle engine start pulses
- np_done, p_done  in  1  engine completion
- np_addr_a, np_addr_b, np_we_b, np_wdata_b  in  engine memory requests; p_* likewise
- mem_addr_a, mem_addr_b, mem_we_b, mem_data_in_b  out  muxed memory controls
- mem_data_out_a  in  DATA_W  memory read data (also fanned out to the engines externally)

## Operation
- States: IDLE, LAUNCH, RUN, FINISH.
- IDLE: port A driven by host_addr; port B by host_addr/host_wdata with we = host_req & host_we & host_gnt.
- host_gnt = IDLE & host_req & ~run_start. run_start wins a same-cycle collision; a held host_req is granted on the first IDLE cycle after the run.
- Granted read: host_rvalid pulses READ_LAT clocks after gnt with mem_data_out_a. The read pipeline completes even if a run starts meanwhile.
- IDLE & run_start: latch run_sel, clear counter, go to LAUNCH.
- LAUNCH: pulse start of the selected engine for one cycle; memory mux switches to that engine. Go to RUN.
- RUN: counter increments every clock, saturating at TIMEOUT.
  - Selected engine done: go to FINISH.
  - Counter == TIMEOUT: pulse run_timeout, go to FINISH.
  - done from the unselected engine is ignored.
- FINISH: latch counter into run_cycles, pulse run_done, return mux to host, go to IDLE.
- run_start while not IDLE is ignored.
- mem_we_b is forced 0 in LAUNCH and FINISH and for the unselected engine.
- Reset (any state, mid-run included): state IDLE, start pulses 0, mem_we_b 0.

## Timing
- Reset values: host_gnt, host_rvalid, run_busy, run_done, run_timeout, np_start, p_start, mem_we_b = 0. run_cycles, host_rdata, mem addresses and data = 0.
- run_busy is high in LAUNCH, RUN and FINISH.
- Start-to-done latency: run_start at edge k, engine start pulse at k+1, done sampled high at edge k+1+N gives run_cycles = N and run_done at k+2+N.
- Host is blocked for N+3 cycles per run.
- Memory mux is registered-select, combinational data path: no added latency to engine accesses.

## Structure
- Shared include fir_defs.vh holds: state encodings, MODE_NP = 0 / MODE_P = 1, default widths.
- Sub-module fir_mem_mux: 3-way port mux (host / np / p) with the write-enable gating. The FSM, counter and read-valid shift register stay in the top.

## Test plan
- Reset mid-RUN (pipelined, counter at 5) -> all outputs return to reset values; next run_start is accepted normally.
- Host writes 64 to addr 0 and 32 to addr 10, then reads both -> host_rvalid 2 clocks after each gnt, rdata 64 and 32; reading addr 20 returns 0.
- run_sel = 0, np_done modelled 40 cycles after np_start -> p_start never pulses, run_cycles = 40, run_done once, run_busy 42 cycles.
- run_sel = 1 with p_done after 12 cycles and a spurious np_done at cycle 3 -> run_cycles = 12, run_timeout = 0.
- Same-cycle run_start and host write -> no write occurs, host_gnt = 0 until FINISH+1, then the write lands.
- Engine never asserts done -> run_timeout pulses at TIMEOUT, run_cycles = 4096, scheduler back in IDLE.
